// File: rtl/ddr_arbiter.sv
// ddr_arbiter
//   Two-port arbiter in front of the single DDRAM Avalon-MM master interface.
//   Port 0 serves the ROM download / tile cache, port 1 the frame buffer.
//   A granted transaction owns the bus for its whole burst. The bus is released
//   when the last write beat is accepted or when the last read beat returns.
//   When both ports request at once, the port that did not win last time is
//   selected.
//
// Ports
//   clk_sys, RESET                 system clock, asynchronous active-high reset
//   inN_rd/wr/addr/burst/mask/din  requester command and write data (N = 0, 1)
//   inN_wait/valid/dout            wait request, read valid, read data to requester
//   ddr_rd/wr/addr/burst/mask/din  command and write data to DDR
//   ddr_dout/waitReq/valid         read data, busy and read valid from DDR
//   grant                          port selected (IDLE) or owning the bus
//   busy                           transaction in progress (state != IDLE)
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic                    clk_sys,
  input  logic                    RESET,

  input  logic                    in0_rd,
  input  logic                    in0_wr,
  input  logic [ADDR_WIDTH-1:0]   in0_addr,
  input  logic [BURST_WIDTH-1:0]  in0_burst,
  input  logic [DATA_WIDTH/8-1:0] in0_mask,
  input  logic [DATA_WIDTH-1:0]   in0_din,
  output logic                    in0_wait,
  output logic                    in0_valid,
  output logic [DATA_WIDTH-1:0]   in0_dout,

  input  logic                    in1_rd,
  input  logic                    in1_wr,
  input  logic [ADDR_WIDTH-1:0]   in1_addr,
  input  logic [BURST_WIDTH-1:0]  in1_burst,
  input  logic [DATA_WIDTH/8-1:0] in1_mask,
  input  logic [DATA_WIDTH-1:0]   in1_din,
  output logic                    in1_wait,
  output logic                    in1_valid,
  output logic [DATA_WIDTH-1:0]   in1_dout,

  output logic                    ddr_rd,
  output logic                    ddr_wr,
  output logic [ADDR_WIDTH-1:0]   ddr_addr,
  output logic [BURST_WIDTH-1:0]  ddr_burst,
  output logic [DATA_WIDTH/8-1:0] ddr_mask,
  output logic [DATA_WIDTH-1:0]   ddr_din,
  input  logic [DATA_WIDTH-1:0]   ddr_dout,
  input  logic                    ddr_waitReq,
  input  logic                    ddr_valid,

  output logic                    grant,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   last_q, last_d;    // port that won the last grant
  logic                   grant_q, grant_d;  // owner of the current burst
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;      // beats still to transfer
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;

  // Port selection. Outside IDLE the registered owner is the only candidate.
  logic req0, req1, sel, owner;

  always_comb begin
    req0 = in0_rd | in0_wr;
    req1 = in1_rd | in1_wr;
    if (req0 && req1)  sel = ~last_q;
    else if (req0)     sel = 1'b0;
    else if (req1)     sel = 1'b1;
    else               sel = grant_q;
    owner = (state_q == ST_IDLE) ? sel : grant_q;
  end

  // Signals of the port that is selected or owns the bus.
  logic                    p_rd, p_wr;
  logic [ADDR_WIDTH-1:0]   p_addr;
  logic [BURST_WIDTH-1:0]  p_burst, burst_norm;
  logic [DATA_WIDTH/8-1:0] p_mask;
  logic [DATA_WIDTH-1:0]   p_din;

  always_comb begin
    p_rd    = owner ? in1_rd    : in0_rd;
    p_wr    = owner ? in1_wr    : in0_wr;
    p_addr  = owner ? in1_addr  : in0_addr;
    p_burst = owner ? in1_burst : in0_burst;
    p_mask  = owner ? in1_mask  : in0_mask;
    p_din   = owner ? in1_din   : in0_din;
    // A zero-length burst is sent to DDR as a single beat.
    burst_norm = (p_burst == '0) ? BURST_ONE : p_burst;
  end

  logic own_wait, own_valid;

  // Next-state and output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    ddr_rd    = 1'b0;
    ddr_wr    = 1'b0;
    ddr_addr  = addr_q;
    ddr_burst = burst_q;
    ddr_mask  = p_mask;
    ddr_din   = p_din;
    own_wait  = 1'b1;
    own_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Zero-latency pass-through. A request with both rd and wr set is a read.
        ddr_rd    = p_rd;
        ddr_wr    = p_wr & ~p_rd;
        ddr_addr  = p_addr;
        ddr_burst = burst_norm;
        own_wait  = ddr_waitReq;
        if ((p_rd | p_wr) && !ddr_waitReq) begin
          last_d  = sel;
          grant_d = sel;
          addr_d  = p_addr;
          burst_d = burst_norm;
          if (p_rd) begin
            state_d = ST_READ;
            cnt_d   = burst_norm;
          end else if (burst_norm != BURST_ONE) begin
            // The first write beat has just been accepted.
            state_d = ST_WRITE;
            cnt_d   = burst_norm - 1'b1;
          end
        end
      end

      ST_READ: begin
        if (ddr_valid) begin
          own_valid = 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == BURST_ONE) state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // Dropping wr only stalls the burst. The other port keeps waiting.
        ddr_wr   = p_wr;
        own_wait = ddr_waitReq;
        if (p_wr && !ddr_waitReq) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BURST_ONE) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // While RESET is high the outputs take their reset values at once,
    // before the registers are cleared.
    if (RESET) begin
      ddr_rd    = 1'b0;
      ddr_wr    = 1'b0;
      own_wait  = 1'b1;
      own_valid = 1'b0;
    end
  end

  assign in0_wait  = owner ? 1'b1 : own_wait;
  assign in1_wait  = owner ? own_wait : 1'b1;
  // A ddr_valid in IDLE or WRITE is dropped because own_valid is only set in READ.
  assign in0_valid = own_valid & ~owner;
  assign in1_valid = own_valid &  owner;
  assign in0_dout  = ddr_dout;
  assign in1_dout  = ddr_dout;
  assign grant     = ~RESET & owner;
  assign busy      = ~RESET & (state_q != ST_IDLE);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;   // port 0 wins the first tie
      grant_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      burst_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every register
      // samples values from before the clock edge.
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter. Random traffic is compared cycle by
// cycle against a transaction-level reference model that tracks the owner,
// the beats still to transfer and the last winner. After the random traffic,
// a directed sequence asserts reset in the middle of a read.
module tb_ddr_arbiter;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [7:0]  burst [2];
  logic [7:0]  mask [2];
  logic [63:0] din [2];
  logic        wait_o [2];
  logic        valid_o [2];
  logic [63:0] dout_o [2];
  logic        ddr_rd, ddr_wr, ddr_waitReq, ddr_valid, grant, busy;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burst, ddr_mask;
  logic [63:0] ddr_din, ddr_dout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_busy;     // a burst owns the bus
  bit          m_is_rd;    // the burst in progress is a read
  int          m_owner;
  int          m_left;     // beats still to transfer
  int          m_last;     // last winner
  int          m_grant;
  logic [31:0] m_addr;
  logic [7:0]  m_burst;

  ddr_arbiter dut (
    .clk_sys     (clk_sys),
    .RESET       (RESET),
    .in0_rd      (rd[0]),
    .in0_wr      (wr[0]),
    .in0_addr    (addr[0]),
    .in0_burst   (burst[0]),
    .in0_mask    (mask[0]),
    .in0_din     (din[0]),
    .in0_wait    (wait_o[0]),
    .in0_valid   (valid_o[0]),
    .in0_dout    (dout_o[0]),
    .in1_rd      (rd[1]),
    .in1_wr      (wr[1]),
    .in1_addr    (addr[1]),
    .in1_burst   (burst[1]),
    .in1_mask    (mask[1]),
    .in1_din     (din[1]),
    .in1_wait    (wait_o[1]),
    .in1_valid   (valid_o[1]),
    .in1_dout    (dout_o[1]),
    .ddr_rd      (ddr_rd),
    .ddr_wr      (ddr_wr),
    .ddr_addr    (ddr_addr),
    .ddr_burst   (ddr_burst),
    .ddr_mask    (ddr_mask),
    .ddr_din     (ddr_din),
    .ddr_dout    (ddr_dout),
    .ddr_waitReq (ddr_waitReq),
    .ddr_valid   (ddr_valid),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_is_rd = 1'b0;
    m_owner = 0;
    m_left  = 0;
    m_last  = 1;
    m_grant = 0;
    m_addr  = '0;
    m_burst = '0;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      rd[p] = 0; wr[p] = 0; addr[p] = '0; burst[p] = '0; mask[p] = '0; din[p] = '0;
    end
    ddr_waitReq = 0; ddr_valid = 0; ddr_dout = '0;
  endtask

  // Called at posedge+1 once the inputs for this cycle have been driven.
  // Compares the outputs at mid-cycle, then applies the model transition at
  // the next edge. Returns at the following posedge+1.
  task automatic step();
    int          s, o, nb;
    bit          e_rd, e_wr, acc;
    bit          e_wait [2];
    bit          e_valid [2];
    bit          e_busy;
    logic [31:0] e_addr;
    logic [7:0]  e_burst;
    bit          cmp_bus;
    bit          n_busy, n_is_rd;
    int          n_owner, n_left, n_last, n_grant;
    logic [31:0] n_addr;
    logic [7:0]  n_burst;
    #4;
    n_busy = m_busy; n_is_rd = m_is_rd; n_owner = m_owner; n_left = m_left;
    n_last = m_last; n_grant = m_grant; n_addr = m_addr; n_burst = m_burst;
    e_wait[0] = 1; e_wait[1] = 1; e_valid[0] = 0; e_valid[1] = 0;
    e_rd = 0; e_wr = 0; cmp_bus = 1;
    e_addr = m_addr; e_burst = m_burst;
    if (!m_busy) begin
      if ((rd[0] | wr[0]) && (rd[1] | wr[1])) s = 1 - m_last;
      else if (rd[0] | wr[0])                 s = 0;
      else if (rd[1] | wr[1])                 s = 1;
      else                                    s = m_grant;
      o      = s;
      nb     = (burst[s] == 0) ? 1 : int'(burst[s]);
      e_rd   = rd[s];
      e_wr   = wr[s] & ~rd[s];
      e_addr = addr[s];
      e_burst = 8'(nb);
      e_wait[s] = ddr_waitReq;
      acc = (e_rd | e_wr) & ~ddr_waitReq;
      if (acc) begin
        n_last = s; n_grant = s; n_owner = s;
        n_addr = addr[s]; n_burst = 8'(nb);
        if (e_rd) begin
          n_busy = 1; n_is_rd = 1; n_left = nb;
        end else if (nb > 1) begin
          n_busy = 1; n_is_rd = 0; n_left = nb - 1;
        end
      end
    end else if (m_is_rd) begin
      o = m_owner;
      cmp_bus = 0;
      e_valid[o] = ddr_valid;
      if (ddr_valid) begin
        n_left = m_left - 1;
        if (n_left == 0) n_busy = 0;
      end
    end else begin
      o = m_owner;
      e_wr = wr[o];
      e_wait[o] = ddr_waitReq;
      if (wr[o] && !ddr_waitReq) begin
        n_left = m_left - 1;
        if (n_left == 0) n_busy = 0;
      end
    end
    e_busy = m_busy;

    check("ddr_rd", 64'(ddr_rd), 64'(e_rd));
    check("ddr_wr", 64'(ddr_wr), 64'(e_wr));
    check("in0_wait", 64'(wait_o[0]), 64'(e_wait[0]));
    check("in1_wait", 64'(wait_o[1]), 64'(e_wait[1]));
    check("in0_valid", 64'(valid_o[0]), 64'(e_valid[0]));
    check("in1_valid", 64'(valid_o[1]), 64'(e_valid[1]));
    check("grant", 64'(grant), 64'(o));
    check("busy", 64'(busy), 64'(e_busy));
    check("in0_dout", dout_o[0], ddr_dout);
    check("in1_dout", dout_o[1], ddr_dout);
    if (cmp_bus) begin
      check("ddr_addr", 64'(ddr_addr), 64'(e_addr));
      check("ddr_burst", 64'(ddr_burst), 64'(e_burst));
      check("ddr_mask", 64'(ddr_mask), 64'(mask[o]));
      check("ddr_din", ddr_din, din[o]);
    end

    @(posedge clk_sys);
    #1;
    m_busy = n_busy; m_is_rd = n_is_rd; m_owner = n_owner; m_left = n_left;
    m_last = n_last; m_grant = n_grant; m_addr = n_addr; m_burst = n_burst;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    // While reset is held, a pending request must not reach DDR.
    RESET = 1;
    rd[0] = 1; burst[0] = 8'd4;
    #1;
    check("rst ddr_rd", 64'(ddr_rd), 64'd0);
    check("rst ddr_wr", 64'(ddr_wr), 64'd0);
    check("rst in0_wait", 64'(wait_o[0]), 64'd1);
    check("rst in1_wait", 64'(wait_o[1]), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst grant", 64'(grant), 64'd0);
    @(posedge clk_sys); #1;
    RESET = 0;
    idle_inputs();

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        int k;
        k = $urandom_range(0, 7);
        rd[p]    = (k == 1) || (k == 2) || (k == 5);
        wr[p]    = (k == 3) || (k == 4) || (k == 5);
        addr[p]  = $urandom;
        burst[p] = 8'($urandom_range(0, 5));
        mask[p]  = 8'($urandom);
        din[p]   = {$urandom, $urandom};
      end
      ddr_waitReq = ($urandom_range(0, 3) == 0);
      ddr_valid   = ($urandom_range(0, 1) == 1);
      ddr_dout    = {$urandom, $urandom};
      step();
    end

    // Reset in the middle of a read that still has two beats outstanding.
    RESET = 1;
    idle_inputs();
    @(posedge clk_sys); #1;
    RESET = 0;
    model_reset();
    rd[0] = 1; addr[0] = 32'h100; burst[0] = 8'd4;
    step();
    rd[0] = 0; ddr_valid = 1;
    step();
    step();
    check("mid busy", 64'(busy), 64'd1);
    #2;
    RESET = 1;
    #1;
    check("async busy", 64'(busy), 64'd0);
    check("async in0_valid", 64'(valid_o[0]), 64'd0);
    check("async in0_wait", 64'(wait_o[0]), 64'd1);
    check("async ddr_rd", 64'(ddr_rd), 64'd0);
    @(posedge clk_sys); #1;
    RESET = 0;
    model_reset();
    // A stray beat after the reset is released must not be forwarded.
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Two-port arbiter sharing the single DDRAM Avalon-MM master interface (clk_sys domain).
- Port 0 is the ROM download/tile-cache path; port 1 is the frame buffer writer/reader.
- Grants whole bursts: a granted transaction owns the DDR bus until its last write beat is accepted or its last read beat returns.
- Round-robin on contention so neither port starves.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
DATA_WIDTH, 64, data beat width
BURST_WIDTH, 8, burst count width

Ports:
clk_sys  in  1  system clock
RESET  in  1  asynchronous active-high reset
in0_rd / in1_rd  in  1  read request
in0_wr / in1_wr  in  1  write request (one beat per accepted cycle)
in0_addr / in1_addr  in  ADDR_WIDTH  burst start address
in0_burst / in1_burst  in  BURST_WIDTH  burst length in beats
in0_mask / in1_mask  in  DATA_WIDTH/8  byte enables
in0_din / in1_din  in  DATA_WIDTH  write data
in0_wait / in1_wait  out  1  wait request to requester
in0_valid / in1_valid  out  1  read data valid to requester
in0_dout / in1_dout  out  DATA_WIDTH  read data (broadcast of ddr_dout)
ddr_rd  out  1  DDR read
ddr_wr  out  1  DDR write
ddr_addr  out  ADDR_WIDTH  DDR address
ddr_burst  out  BURST_WIDTH  DDR burst count
ddr_mask  out  DATA_WIDTH/8  DDR byte enables
ddr_din  out  DATA_WIDTH  DDR write data
ddr_dout  in  DATA_WIDTH  DDR read data
ddr_waitReq  in  1  DDR busy
ddr_valid  in  1  DDR read data valid
grant  out  1  port owning/selected for the bus
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock clk_sys; reset RESET, asynchronous, active-high. Reset: state IDLE, last-winner = port 1 (port 0 wins the first tie), beat counter 0, grant 0.
- Reset output values: ddr_rd=0, ddr_wr=0, in0_wait=in1_wait=1, in0_valid=in1_valid=0, busy=0.
- States: IDLE, READ, WRITE.
- IDLE selection (combinational):
  - Only one port requesting (rd|wr): that port is selected.
  - Both requesting: the port that did not win last is selected.
  - No request: grant holds its previous value.
- IDLE pass-through: the selected port's rd/wr/addr/burst/mask/din drive ddr_* in the same cycle (zero-cycle latency).
- Wait rule:
  - inN_wait = ddr_waitReq when port N is selected/owner and the state accepts commands.
  - Otherwise inN_wait = 1.
- Acceptance: command accepted when (ddr_rd|ddr_wr) & ~ddr_waitReq. On acceptance, last-winner is updated and grant is latched.
- Request encoding:
  - rd and wr both high on one port is treated as a read; ddr_wr is forced to 0.
  - burst = 0 is treated as 1 and forwarded as 1.
- IDLE transitions:
  - Read accepted -> READ; counter = burst.
  - Write accepted with burst = 1 -> stays IDLE.
  - Write accepted with burst > 1 -> WRITE; counter = burst - 1.
- READ:
  - ddr_rd = ddr_wr = 0; both waits = 1.
  - Each ddr_valid asserts valid to the owner only and decrements the counter.
  - At the beat where counter = 1 -> IDLE.
  - A new grant is issued no earlier than the next cycle.
- WRITE:
  - Only the owner's wr/din/mask pass through; ddr_addr/ddr_burst hold the latched values.
  - Each accepted beat decrements the counter; the last accepted beat -> IDLE.
  - Owner deasserting wr mid-burst stalls the burst; it is never aborted.
  - The other port waits regardless of priority.
- ddr_valid in IDLE or WRITE is dropped (not forwarded) and does not change state.
- inN_dout = ddr_dout unconditionally; consumers qualify with inN_valid.
- Counter is BURST_WIDTH bits and never wraps: max burst 2^BURST_WIDTH-1.
- Reset mid-burst: return to IDLE immediately. An outstanding DDR burst is not tracked; the system reset is required to reset DDR users too.

Test Plan:
- Single read: in0_rd, burst=4, addr=0x100, waitReq low -> ddr_rd=1 same cycle, ddr_addr=0x100; 4 ddr_valid pulses -> in0_valid 4×, in1_valid 0; busy falls after the 4th.
- Tie: in0_rd and in1_wr in the same cycle after reset -> port 0 granted first, port 1 granted in the cycle after port 0's last read beat; next tie -> port 0 loses.
- Write burst 8 from port 1 with in0_rd asserted throughout -> in0_wait stays 1 for all 8 beats; ddr_addr constant; port 0 granted after the 8th accepted beat.
- Backpressure: ddr_waitReq high 3 cycles on the first write beat -> in1_wait high 3 cycles, no counter change, no lost beat; 4 beats total on ddr_wr for burst=4.
- burst=0 read -> ddr_burst=1, exactly one valid, back to IDLE.
- RESET asserted during READ with 2 beats outstanding -> outputs at reset values asynchronously; stray ddr_valid after release is not forwarded.
